// File: rtl/data_port_ctrl.sv
// CPU data-port decoder: RAM pass-through, LED register, UART TX FIFO,
// 64-bit cycle counter with a high-word snapshot, one-cycle read latency.
module data_port_ctrl #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] cpuAddress,
    input  logic [31:0] cpuWrData,
    input  logic        cpuWrEn,
    output logic [31:0] cpuRdData,
    output logic [12:0] ramAddress,
    output logic [31:0] ramWrData,
    output logic        ramWrEn,
    input  logic [31:0] ramRdData,
    output logic [7:0]  ledOut,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [13:0] ADDR_LED   = 14'h2000;
    localparam logic [13:0] ADDR_TX    = 14'h2001;
    localparam logic [13:0] ADDR_CNTLO = 14'h2002;
    localparam logic [13:0] ADDR_CNTHI = 14'h2003;
    localparam logic [13:0] ADDR_CLR   = 14'h2004;

    logic [7:0]  fifoMem [FIFO_DEPTH];
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    logic [AW:0] level;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        accept;
    logic [7:0]  dropCount;
    logic [63:0] cycleCnt;
    logic [31:0] cntHiSnap;
    logic [31:0] ioRdData;
    logic [31:0] ioRdNext;
    logic [31:0] status;
    logic        selIo;
    logic        rdValid;
    logic        wrLed;
    logic        wrClr;
    logic        rdCntLo;

    assign ramAddress = cpuAddress[12:0];
    assign ramWrData  = cpuWrData;
    assign ramWrEn    = cpuWrEn && !cpuAddress[13];

    assign wrLed   = cpuWrEn && (cpuAddress == ADDR_LED);
    assign wrClr   = cpuWrEn && (cpuAddress == ADDR_CLR);
    assign push    = cpuWrEn && (cpuAddress == ADDR_TX);
    assign rdCntLo = !cpuWrEn && (cpuAddress == ADDR_CNTLO);

    // Extra MSB on the pointers separates full from empty.
    assign level = wrPtr - rdPtr;
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW])
                && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

    assign txValid = !empty;
    assign txData  = fifoMem[rdPtr[AW-1:0]];
    assign pop     = txValid && txReady;
    assign accept  = push && (!full || pop);

    assign status = {8'h0, dropCount, 8'(level), 6'h0, full, empty};

    always_comb begin
        ioRdNext = '0;
        unique case (1'b1)
            cpuAddress == ADDR_LED:   ioRdNext = {24'h0, ledOut};
            cpuAddress == ADDR_TX:    ioRdNext = status;
            cpuAddress == ADDR_CNTLO: ioRdNext = cycleCnt[31:0];
            cpuAddress == ADDR_CNTHI: ioRdNext = cntHiSnap;
            default:                  ioRdNext = '0;
        endcase
    end

    // rdValid keeps the load bus at zero until the first post-reset edge.
    assign cpuRdData = !rdValid ? '0 : (selIo ? ioRdData : ramRdData);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            dropCount <= '0;
            ledOut    <= '0;
            cycleCnt  <= '0;
            cntHiSnap <= '0;
            ioRdData  <= '0;
            selIo     <= 1'b0;
            rdValid   <= 1'b0;
        end else begin
            cycleCnt <= cycleCnt + 64'd1;
            rdValid  <= 1'b1;
            selIo    <= cpuAddress[13];
            ioRdData <= ioRdNext;
            if (rdCntLo)
                cntHiSnap <= cycleCnt[63:32];
            if (wrLed)
                ledOut <= cpuWrData[7:0];
            if (accept)
                wrPtr <= wrPtr + PTR_ONE;
            if (pop)
                rdPtr <= rdPtr + PTR_ONE;
            if (wrClr)
                dropCount <= '0;
            else if (push && !accept && dropCount != 8'hFF)
                dropCount <= dropCount + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            fifoMem[wrPtr[AW-1:0]] <= cpuWrData[7:0];
    end
endmodule

// File: tb/tb_data_port_ctrl.sv
// Bench for data_port_ctrl: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_data_port_ctrl;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] cpuAddress;
    logic [31:0] cpuWrData;
    logic        cpuWrEn;
    logic [31:0] cpuRdData;
    logic [12:0] ramAddress;
    logic [31:0] ramWrData;
    logic        ramWrEn;
    logic [31:0] ramRdData;
    logic [7:0]  ledOut;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;

    always #5 clk = ~clk;

    data_port_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .cpuAddress(cpuAddress),
        .cpuWrData(cpuWrData),
        .cpuWrEn(cpuWrEn),
        .cpuRdData(cpuRdData),
        .ramAddress(ramAddress),
        .ramWrData(ramWrData),
        .ramWrEn(ramWrEn),
        .ramRdData(ramRdData),
        .ledOut(ledOut),
        .txData(txData),
        .txValid(txValid),
        .txReady(txReady)
    );

    // External synchronous RAM.
    logic [31:0] ram [8192];
    always @(posedge clk) begin
        if (ramWrEn)
            ram[ramAddress] <= ramWrData;
        ramRdData <= ram[ramAddress];
    end

    logic [7:0]  q[$];
    logic [7:0]  emitted[$];
    int unsigned dropM;
    logic [7:0]  ledM;
    logic [63:0] cntM;
    logic [31:0] snapM;
    int nChecks = 0;
    int nFails = 0;

    typedef struct {
        logic [13:0] a;
        logic [31:0] d;
        logic        w;
        logic        chkRd;
        logic [31:0] rd;
        logic [7:0]  led;
        logic        vld;
        logic [7:0]  tx;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic [13:0] a, input logic [31:0] d,
                                input logic w, input logic chkRd,
                                input logic [31:0] rd, input logic [7:0] led,
                                input logic vld, input logic [7:0] tx);
        vec_t v;
        v.a = a; v.d = d; v.w = w; v.chkRd = chkRd;
        v.rd = rd; v.led = led; v.vld = vld; v.tx = tx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        dropM = 0;
        ledM  = 8'h0;
        cntM  = 64'h0;
        snapM = 32'h0;
    endtask

    function automatic logic [31:0] statusM();
        logic isFull;
        logic isEmpty;
        isFull  = (q.size() == DEPTH);
        isEmpty = (q.size() == 0);
        return {8'h0, 8'(dropM), 8'(q.size()), 6'h0, isFull, isEmpty};
    endfunction

    // One cycle: drive after negedge, model the edge, check after posedge.
    task automatic step(input logic [13:0] a, input logic [31:0] d,
                        input logic w, input logic r);
        logic [31:0] expRd;
        bit isFull;
        bit isPop;
        cpuAddress = a;
        cpuWrData  = d;
        cpuWrEn    = w;
        txReady    = r;
        #1;
        chk("ramWrEn", ramWrEn, w && !a[13]);
        chk("ramAddress", ramAddress, a[12:0]);
        chk("ramWrData", ramWrData, d);
        if (txValid && r)
            emitted.push_back(txData);
        if (!a[13])
            expRd = ram[a[12:0]];
        else if (a == 14'h2000)
            expRd = {24'h0, ledM};
        else if (a == 14'h2001)
            expRd = statusM();
        else if (a == 14'h2002)
            expRd = cntM[31:0];
        else if (a == 14'h2003)
            expRd = snapM;
        else
            expRd = 32'h0;
        isFull = (q.size() == DEPTH);
        isPop  = (q.size() > 0) && r;
        if (isPop)
            void'(q.pop_front());
        if (w && a == 14'h2001) begin
            if (!isFull || isPop)
                q.push_back(d[7:0]);
            else if (dropM < 255)
                dropM++;
        end
        if (w && a == 14'h2004)
            dropM = 0;
        if (w && a == 14'h2000)
            ledM = d[7:0];
        if (!w && a == 14'h2002)
            snapM = cntM[63:32];
        cntM++;
        @(posedge clk);
        #1;
        if (!w)
            chk("cpuRdData", cpuRdData, expRd);
        chk("ledOut", ledOut, ledM);
        chk("txValid", txValid, q.size() != 0);
        if (q.size() != 0)
            chk("txData", txData, q[0]);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        cpuAddress = '0;
        cpuWrData = '0;
        cpuWrEn = 1'b0;
        txReady = 1'b0;

        vecs.push_back(mk(14'h2000, 32'h1A5, 1, 0, 0, 8'hA5, 0, 0));
        vecs.push_back(mk(14'h2000, 0, 0, 1, 32'hA5, 8'hA5, 0, 0));
        vecs.push_back(mk(14'h0123, 32'hDEADBEEF, 1, 0, 0, 8'hA5, 0, 0));
        vecs.push_back(mk(14'h0123, 0, 0, 1, 32'hDEADBEEF, 8'hA5, 0, 0));
        vecs.push_back(mk(14'h2000, 32'h3C, 1, 0, 0, 8'h3C, 0, 0));
        vecs.push_back(mk(14'h2005, 0, 0, 1, 32'h0, 8'h3C, 0, 0));
        for (int i = 1; i <= 10; i++)
            vecs.push_back(mk(14'h2001, i, 1, 0, 0, 8'h3C, 1, 8'h01));
        vecs.push_back(mk(14'h2001, 0, 0, 1, 32'h00020802, 8'h3C, 1, 8'h01));
        vecs.push_back(mk(14'h2004, 0, 1, 0, 0, 8'h3C, 1, 8'h01));
        vecs.push_back(mk(14'h2001, 0, 0, 1, 32'h00000802, 8'h3C, 1, 8'h01));

        @(posedge clk);
        #1;
        chk("rst_led", ledOut, 8'h0);
        chk("rst_txValid", txValid, 1'b0);
        chk("rst_rdData", cpuRdData, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();

        step(14'h2002, 0, 0, 0);
        chk("first_cnt", cpuRdData, 32'h0);
        step(14'h2002, 0, 0, 0);
        chk("second_cnt", cpuRdData, 32'h1);

        foreach (vecs[i]) begin
            step(vecs[i].a, vecs[i].d, vecs[i].w, 1'b0);
            if (vecs[i].chkRd)
                chk($sformatf("vec%0d_rd", i), cpuRdData, vecs[i].rd);
            chk($sformatf("vec%0d_led", i), ledOut, vecs[i].led);
            chk($sformatf("vec%0d_vld", i), txValid, vecs[i].vld);
            if (vecs[i].vld)
                chk($sformatf("vec%0d_tx", i), txData, vecs[i].tx);
        end

        // Drain: exactly 0x01..0x08 in order.
        emitted.delete();
        for (int i = 0; i < 10; i++)
            step(14'h2005, 0, 0, 1);
        chk("drain_count", emitted.size(), 8);
        for (int i = 0; i < emitted.size() && i < 8; i++)
            chk($sformatf("drain_byte%0d", i), emitted[i], i + 1);
        chk("drain_empty", txValid, 1'b0);

        // Full FIFO: push on the same edge as a pop is accepted.
        emitted.delete();
        for (int i = 0; i < DEPTH; i++)
            step(14'h2001, 32'h10 + i, 1, 0);
        step(14'h2001, 32'h55, 1, 1);
        for (int i = 0; i < 12; i++)
            step(14'h2005, 0, 0, 1);
        chk("fullpop_count", emitted.size(), DEPTH + 1);
        if (emitted.size() > 0) begin
            chk("fullpop_first", emitted[0], 8'h10);
            chk("fullpop_last", emitted[emitted.size()-1], 8'h55);
        end
        step(14'h2001, 0, 0, 0);
        chk("fullpop_status", cpuRdData, 32'h00000001);

        // Counter carry and high snapshot.
        force dut.cycleCnt = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycleCnt;
        cntM = 64'h0000_0000_FFFF_FFFF;
        step(14'h2002, 0, 0, 0);
        chk("carry_lo", cpuRdData, 32'hFFFFFFFF);
        step(14'h2003, 0, 0, 0);
        chk("carry_hi", cpuRdData, 32'h0);
        step(14'h2002, 0, 0, 0);
        chk("post_lo", cpuRdData, 32'h1);
        step(14'h2003, 0, 0, 0);
        chk("post_hi", cpuRdData, 32'h1);

        // Async reset with 3 bytes queued and dropCount=4.
        step(14'h2000, 32'h77, 1, 0);
        for (int i = 0; i < 12; i++)
            step(14'h2001, 32'h20 + i, 1, 0);
        for (int i = 0; i < 5; i++)
            step(14'h2005, 0, 0, 1);
        step(14'h2001, 0, 0, 0);
        chk("pre_rst_status", cpuRdData, 32'h00040300);
        cpuAddress = 14'h2001;
        cpuWrEn = 1'b0;
        txReady = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_txValid", txValid, 1'b0);
        chk("async_led", ledOut, 8'h0);
        chk("async_rd", cpuRdData, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_txValid", txValid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        step(14'h2001, 0, 0, 1);
        chk("post_rst_status", cpuRdData, 32'h00000001);
        step(14'h2002, 0, 0, 0);
        chk("post_rst_cnt", cpuRdData, 32'h1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int sel;
            logic [13:0] a;
            logic w;
            sel = $urandom_range(0, 15);
            w = 1'b0;
            if (sel <= 4) begin
                a = 14'h2001;
                w = 1'b1;
            end else if (sel == 5)
                a = 14'h2001;
            else if (sel == 6) begin
                a = 14'h2000;
                w = 1'($urandom_range(0, 1));
            end else if (sel == 7)
                a = 14'h2002;
            else if (sel == 8)
                a = 14'h2003;
            else if (sel == 9) begin
                a = 14'h2004;
                w = ($urandom_range(0, 3) == 0);
            end else if (sel == 10) begin
                a = 14'(14'h2005 + $urandom_range(0, 14'h1FFA));
                w = 1'($urandom_range(0, 1));
            end else begin
                a = 14'($urandom_range(0, 15));
                w = 1'($urandom_range(0, 1));
            end
            step(a, $urandom, w, $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/data_port_ctrl.md
DATA_PORT_CTRL -- requirements
Module: data_port_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, TX FIFO entries; SHALL be a power of 2, from 2 to 64.
REQ-002 Port: clk  in  1  rising-edge clock for all state.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: cpuAddress  in  14  CPU data address.
REQ-005 Port: cpuWrData  in  32  CPU store data.
REQ-006 Port: cpuWrEn  in  1  CPU store strobe, sampled together with cpuAddress and cpuWrData.
REQ-007 Port: cpuRdData  out  32  load data returned to the CPU.
REQ-008 Port: ramAddress  out  13  equals cpuAddress[12:0], combinational.
REQ-009 Port: ramWrData  out  32  equals cpuWrData, combinational.
REQ-010 Port: ramWrEn  out  1  equals cpuWrEn AND NOT cpuAddress[13].
REQ-011 Port: ramRdData  in  32  synchronous RAM read data, valid one cycle after the address.
REQ-012 Port: ledOut  out  8  LED register.
REQ-013 Port: txData  out  8  head byte of the TX FIFO.
REQ-014 Port: txValid  out  1  high when the FIFO is not empty.
REQ-015 Port: txReady  in  1  the UART accepts a byte.

Function
REQ-016 The address map SHALL be: 0x0000-0x1FFF RAM; 0x2000 LED (R/W); 0x2001 TX push (W) / status (R); 0x2002 cycle counter low (R); 0x2003 cycle counter high snapshot (R); 0x2004 status clear (W); all other addresses read 0 and ignore writes.
REQ-017 Read latency SHALL be exactly 1 cycle: cpuRdData in cycle N+1 reflects the address presented in cycle N.
- RAM region: ramRdData passes through, muxed by a registered region select.
- IO region: registered IO read data.
REQ-018 Reads SHALL have no side effects, except a read of 0x2002, which SHALL also capture counter[63:32] into the high snapshot register.
REQ-019 An LED write SHALL load cpuWrData[7:0] into ledOut at the write edge.
- A read of 0x2000 SHALL return {24'h0, ledOut}.
REQ-020 The cycle counter SHALL be 64 bits and increment every cycle.
- It SHALL wrap from all-ones to 0.
- A read of 0x2002 in cycle N SHALL return the counter value at the cycle-N edge.
REQ-021 A write to 0x2001 SHALL push cpuWrData[7:0] into the TX FIFO.
- The push is accepted if the FIFO is not full, or if a pop occurs on the same edge.
- Otherwise the byte is discarded and dropCount increments, saturating at 255.
REQ-022 A pop SHALL occur when txValid AND txReady are high at a rising edge.
- txData SHALL present the head byte (show-ahead) and SHALL stay stable while txValid=1 and txReady=0.
REQ-023 Simultaneous push and pop SHALL leave the level unchanged.
- When the FIFO is empty, push and pop cannot coincide, because txValid=0.
REQ-024 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
- full: pointers differ only in the MSB.
- empty: pointers are equal.
REQ-025 A status read (0x2001) SHALL return {8'h0, dropCount, level[7:0], 6'h0, full, empty}.
REQ-026 Any write to 0x2004 SHALL clear dropCount, with priority over a same-cycle increment.
- FIFO contents and the counter SHALL be unaffected.
REQ-027 Writes to the IO region SHALL never assert ramWrEn.

Reset
REQ-028 While rst is high, all state SHALL be cleared asynchronously:
- ledOut=0, cpuRdData=0, txValid=0, FIFO empty, dropCount=0, cycle counter=0, high snapshot=0, region select=RAM.
REQ-029 Reset asserted mid-transfer SHALL discard all FIFO contents.
- No pop is counted on the reset edge.
REQ-030 The first counter increment SHALL occur on the first rising edge after rst deasserts, giving counter=1.

Verification
REQ-031 Write 0x2000=0x000001A5, then read 0x2000 -> ledOut=0xA5 after the write edge; cpuRdData=0x000000A5 one cycle after the read address.
REQ-032 With txReady=0, push 10 bytes 0x01..0x0A (FIFO_DEPTH=8) -> status reads full=1, level=8, dropCount=2; txData=0x01 held. Raise txReady -> bytes 0x01..0x08 emitted in order, then txValid=0.
REQ-033 Fill the FIFO, hold txReady=1, push 0x55 on the same edge as a pop -> push accepted, dropCount unchanged, 0x55 emitted last.
REQ-034 Store 0xDEADBEEF to 0x0123, then load 0x0123 with a RAM model -> ramWrEn high only for the store; cpuRdData=0xDEADBEEF one cycle after the load address. A store to 0x2000 -> ramWrEn=0.
REQ-035 Preload the counter to 0x00000000_FFFFFFFF via reset-release timing or a force, then read 0x2002 then 0x2003 -> 0xFFFFFFFF, then 0x00000000 (snapshot taken before the carry); the next 0x2002/0x2003 pair -> 0x0000000x / 0x00000001.
REQ-036 Assert rst asynchronously mid-cycle with the FIFO holding 3 bytes and dropCount=4 -> txValid, ledOut and cpuRdData fall immediately; after release, status reads 0x00000001.
